// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch port, data port and memory-controller port of the
// memory arbiter. The master view is the arbiter itself: it takes requests
// and read data in, and drives ready/response and memory command signals out.
// The slave view is the environment around it (requesters plus RAM path).
interface memory_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  // instruction-fetch port
  logic                  if_req;
  logic [DATA_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic                  if_resp_valid;
  logic [DATA_WIDTH-1:0] if_resp_data;
  logic                  if_resp_error;
  // load/store port
  logic                  d_req;
  logic                  d_store;
  logic [DATA_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [1:0]            d_length;
  logic                  d_unsigned;
  logic                  d_ready;
  logic                  d_resp_valid;
  logic [DATA_WIDTH-1:0] d_resp_data;
  logic                  d_resp_error;
  // memory-controller port
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [1:0]            mem_length;
  logic                  mem_unsigned;
  logic                  mem_store;
  logic                  mem_load;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_store, d_addr, d_wdata, d_length, d_unsigned,
    input  mem_rdata,
    output if_ready, if_resp_valid, if_resp_data, if_resp_error,
    output d_ready, d_resp_valid, d_resp_data, d_resp_error,
    output mem_addr, mem_wdata, mem_length, mem_unsigned, mem_store, mem_load
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_store, d_addr, d_wdata, d_length, d_unsigned,
    output mem_rdata,
    input  if_ready, if_resp_valid, if_resp_data, if_resp_error,
    input  d_ready, d_resp_valid, d_resp_data, d_resp_error,
    input  mem_addr, mem_wdata, mem_length, mem_unsigned, mem_store, mem_load
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single memory-controller port between the
// instruction-fetch requester and the load/store unit. Round-robin grant,
// one strobe per transaction, fixed RAM read latency, one transaction in
// flight. Request fields are latched at accept and drive the memory port
// until the next accept so downstream read-data alignment sees them stable.
module memory_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1   // 1..4
) (
  input  logic             clk,
  input  logic             reset,
  memory_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic       OWNER_FETCH = 1'b0;
  localparam logic       OWNER_DATA  = 1'b1;
  localparam logic [2:0] CNT_INIT    = 3'(RAM_LATENCY - 1);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [1:0]            length_reg;
  logic                  unsigned_reg;
  logic                  store_reg;
  logic                  owner_reg;
  logic                  last_grant_reg;
  logic [2:0]            cnt_reg;

  logic grant_fetch;
  logic grant_data;
  logic misaligned;
  logic resp_valid;
  logic resp_error;
  logic [DATA_WIDTH-1:0] resp_data;

  // Round-robin choice: a lone requester wins, on a tie the port not granted last wins.
  always_comb begin
    grant_fetch = bus.if_req && (!bus.d_req || (last_grant_reg == OWNER_DATA));
    grant_data  = bus.d_req && !grant_fetch;
  end

  // Alignment/legality of the latched request; length 2 is never legal.
  always_comb begin
    misaligned = (length_reg == 2'd2) ||
                 ((length_reg == 2'd1) && addr_reg[0]) ||
                 ((length_reg == 2'd3) && (addr_reg[1:0] != 2'b00));
  end

  // Sequencer: accept in IDLE, strobe in ACCESS, count down the RAM latency in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      length_reg     <= 2'd0;
      unsigned_reg   <= 1'b0;
      store_reg      <= 1'b0;
      owner_reg      <= OWNER_FETCH;
      last_grant_reg <= OWNER_DATA;  // fetch wins the first tie
      cnt_reg        <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_fetch) begin
            addr_reg       <= bus.if_addr;
            wdata_reg      <= '0;
            length_reg     <= 2'd3;
            unsigned_reg   <= 1'b1;
            store_reg      <= 1'b0;
            owner_reg      <= OWNER_FETCH;
            last_grant_reg <= OWNER_FETCH;
            state_reg      <= ACCESS;
          end else if (grant_data) begin
            addr_reg       <= bus.d_addr;
            wdata_reg      <= bus.d_wdata;
            length_reg     <= bus.d_length;
            unsigned_reg   <= bus.d_unsigned;
            store_reg      <= bus.d_store;
            owner_reg      <= OWNER_DATA;
            last_grant_reg <= OWNER_DATA;
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          if (misaligned || store_reg) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg   <= CNT_INIT;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg != 3'd0) begin
            cnt_reg <= cnt_reg - 3'd1;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Strobes and response decode; read data is passed straight through in the last WAIT cycle.
  always_comb begin
    resp_valid    = 1'b0;
    resp_error    = 1'b0;
    resp_data     = '0;
    bus.mem_load  = 1'b0;
    bus.mem_store = 1'b0;
    case (state_reg)
      ACCESS: begin
        if (misaligned) begin
          resp_valid = 1'b1;
          resp_error = 1'b1;
        end else if (store_reg) begin
          bus.mem_store = 1'b1;
          resp_valid    = 1'b1;
        end else begin
          bus.mem_load = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_reg == 3'd0) begin
          resp_valid = 1'b1;
          resp_data  = bus.mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Ready only in IDLE (masked while reset is held); responses steered to the owner only.
  always_comb begin
    bus.if_ready      = !reset && (state_reg == IDLE) && grant_fetch;
    bus.d_ready       = !reset && (state_reg == IDLE) && grant_data;
    bus.if_resp_valid = resp_valid && (owner_reg == OWNER_FETCH);
    bus.if_resp_error = resp_error && (owner_reg == OWNER_FETCH);
    bus.if_resp_data  = (owner_reg == OWNER_FETCH) ? resp_data : '0;
    bus.d_resp_valid  = resp_valid && (owner_reg == OWNER_DATA);
    bus.d_resp_error  = resp_error && (owner_reg == OWNER_DATA);
    bus.d_resp_data   = (owner_reg == OWNER_DATA) ? resp_data : '0;
    bus.mem_addr      = addr_reg;
    bus.mem_wdata     = wdata_reg;
    bus.mem_length    = length_reg;
    bus.mem_unsigned  = unsigned_reg;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: four instances with RAM_LATENCY 1..4 share one
// clock. Directed vector table, hand-written multi-cycle sequences, and a
// randomized run per instance against a transaction-level reference model.
`timescale 1ns/1ps
module tb_memory_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       reset_v   = '1;
  logic [N-1:0]       if_req_v  = '0;
  logic [N-1:0]       d_req_v   = '0;
  logic [N-1:0]       d_store_v = '0;
  logic [N-1:0]       d_uns_v   = '0;
  logic [N-1:0][31:0] if_addr_v = '0;
  logic [N-1:0][31:0] d_addr_v  = '0;
  logic [N-1:0][31:0] d_wdata_v = '0;
  logic [N-1:0][1:0]  d_len_v   = '0;

  logic [N-1:0]       if_ready_v, if_rv_v, if_re_v, d_ready_v, d_rv_v, d_re_v;
  logic [N-1:0]       m_ld_v, m_st_v, m_uns_v;
  logic [N-1:0][31:0] if_rd_v, d_rd_v, m_addr_v, m_wdata_v;
  logic [N-1:0][1:0]  m_len_v;

  int n_tests = 0;
  int n_fail  = 0;

  // RAM contents seen through the controller: one special word, the rest a pattern.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    memory_arbiter_if #(.DATA_WIDTH(32)) bus ();
    logic [2:0] since = 3'd0;

    // RAM model: read data is valid exactly RAM_LATENCY cycles after the load strobe.
    always @(posedge clk) begin
      if (reset_v[gi])               since <= 3'd0;
      else if (bus.mem_load)         since <= 3'd1;
      else if (since != 3'd0 && since != 3'd7) since <= since + 3'd1;
    end

    assign bus.if_req     = if_req_v[gi];
    assign bus.if_addr    = if_addr_v[gi];
    assign bus.d_req      = d_req_v[gi];
    assign bus.d_store    = d_store_v[gi];
    assign bus.d_addr     = d_addr_v[gi];
    assign bus.d_wdata    = d_wdata_v[gi];
    assign bus.d_length   = d_len_v[gi];
    assign bus.d_unsigned = d_uns_v[gi];
    assign bus.mem_rdata  = (since == 3'(gi + 1)) ? ram_word(bus.mem_addr) : 32'h0BAD_0BAD;

    assign if_ready_v[gi] = bus.if_ready;
    assign if_rv_v[gi]    = bus.if_resp_valid;
    assign if_rd_v[gi]    = bus.if_resp_data;
    assign if_re_v[gi]    = bus.if_resp_error;
    assign d_ready_v[gi]  = bus.d_ready;
    assign d_rv_v[gi]     = bus.d_resp_valid;
    assign d_rd_v[gi]     = bus.d_resp_data;
    assign d_re_v[gi]     = bus.d_resp_error;
    assign m_addr_v[gi]   = bus.mem_addr;
    assign m_wdata_v[gi]  = bus.mem_wdata;
    assign m_len_v[gi]    = bus.mem_length;
    assign m_uns_v[gi]    = bus.mem_unsigned;
    assign m_st_v[gi]     = bus.mem_store;
    assign m_ld_v[gi]     = bus.mem_load;

    memory_arbiter #(.DATA_WIDTH(32), .RAM_LATENCY(gi + 1)) dut (
      .clk   (clk),
      .reset (reset_v[gi]),
      .bus   (bus)
    );
  end

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat=%0d): got %h, expected %h", name, idx + 1, act, exp);
    end
  endtask

  task automatic chk_zero(input string name, input int idx);
    chk({name, "_ctrl"}, idx, 64'({if_ready_v[idx], d_ready_v[idx], if_rv_v[idx], if_re_v[idx],
                                   d_rv_v[idx], d_re_v[idx], m_ld_v[idx], m_st_v[idx],
                                   m_uns_v[idx], m_len_v[idx]}), 64'd0);
    chk({name, "_addr_wdata"}, idx, {m_addr_v[idx], m_wdata_v[idx]}, 64'd0);
    chk({name, "_rdata"}, idx, {if_rd_v[idx], d_rd_v[idx]}, 64'd0);
  endtask

  // Reset with both requests asserted: every output must read 0, ready included.
  task automatic do_reset(input int idx);
    @(negedge clk);
    if_req_v[idx] = 1'b1;
    d_req_v[idx]  = 1'b1;
    d_len_v[idx]  = 2'd3;
    reset_v[idx]  = 1'b1;
    #1;
    chk_zero("reset", idx);
    @(negedge clk);
    if_req_v[idx] = 1'b0;
    d_req_v[idx]  = 1'b0;
    reset_v[idx]  = 1'b0;
  endtask

  typedef struct {
    int          dut;
    logic        is_data;
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  len;
    logic        uns;
    int          delay;     // accept-to-response cycles
    logic        exp_err;
    logic        exp_ld;
    logic        exp_st;
    logic [31:0] exp_data;
  } vec_t;

  // Issue one request, then check strobe, held memory fields and response timing.
  task automatic run_vec(input vec_t v);
    int   idx = v.dut;
    int   waited = 0;
    logic own_v, oth_v, own_e;
    logic [31:0] own_d, oth_d;
    @(negedge clk);
    if (v.is_data) begin
      d_req_v[idx]   = 1'b1;
      d_store_v[idx] = v.store;
      d_addr_v[idx]  = v.addr;
      d_wdata_v[idx] = v.wdata;
      d_len_v[idx]   = v.len;
      d_uns_v[idx]   = v.uns;
    end else begin
      if_req_v[idx]  = 1'b1;
      if_addr_v[idx] = v.addr;
    end
    #1;
    while (!(v.is_data ? d_ready_v[idx] : if_ready_v[idx]) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("vec_accept", idx, 64'(v.is_data ? d_ready_v[idx] : if_ready_v[idx]), 64'd1);
    chk("vec_other_ready", idx, 64'(v.is_data ? if_ready_v[idx] : d_ready_v[idx]), 64'd0);
    @(negedge clk);
    if_req_v[idx] = 1'b0;
    d_req_v[idx]  = 1'b0;
    #1;
    for (int k = 1; k <= v.delay; k++) begin
      own_v = v.is_data ? d_rv_v[idx] : if_rv_v[idx];
      oth_v = v.is_data ? if_rv_v[idx] : d_rv_v[idx];
      own_e = v.is_data ? d_re_v[idx] : if_re_v[idx];
      own_d = v.is_data ? d_rd_v[idx] : if_rd_v[idx];
      oth_d = v.is_data ? if_rd_v[idx] : d_rd_v[idx];
      chk("vec_resp_valid", idx, 64'(own_v), 64'(k == v.delay));
      chk("vec_other_port", idx, 64'({oth_v, oth_d}), 64'd0);
      chk("vec_mem_fields", idx, 64'({m_len_v[idx], m_uns_v[idx], m_addr_v[idx]}),
          64'({(v.is_data ? v.len : 2'd3), (v.is_data ? v.uns : 1'b1), v.addr}));
      if (k == 1) begin
        chk("vec_strobes", idx, 64'({m_ld_v[idx], m_st_v[idx]}), 64'({v.exp_ld, v.exp_st}));
        if (v.exp_st) chk("vec_mem_wdata", idx, 64'(m_wdata_v[idx]), 64'(v.wdata));
      end else begin
        chk("vec_strobes_idle", idx, 64'({m_ld_v[idx], m_st_v[idx]}), 64'd0);
      end
      if (k == v.delay) begin
        chk("vec_resp_err_data", idx, 64'({own_e, own_d}), 64'({v.exp_err, v.exp_data}));
      end else begin
        @(negedge clk);
        #1;
      end
    end
    $display("[TB] vec lat=%0d %s addr=%h len=%0d store=%0b -> err=%0b data=%h",
             idx + 1, v.is_data ? "data " : "fetch", v.addr, v.len, v.store, own_e, own_d);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
    return a;
  endfunction

  // Randomized traffic against a transaction-level model: at most one transaction
  // in flight, next accept no earlier than the cycle after its response.
  task automatic rand_run(input int idx, input int ncyc);
    int          lat = idx + 1;
    logic        f_act = 1'b0, d_act = 1'b0;
    logic [31:0] f_addr = '0, dd_addr = '0, dd_wdata = '0;
    logic [1:0]  dd_len = 2'd0;
    logic        dd_st = 1'b0, dd_uns = 1'b0;
    int          free_cyc = 0;
    logic        last_data = 1'b1;
    logic        c_data = 1'b0, c_uns = 1'b0, c_st = 1'b0, c_err = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, expd;
    logic [1:0]  c_len = 2'd0;
    int          acc = -100, rsp = -100;
    logic        gf, gd, e_ld, e_st;
    do_reset(idx);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (!f_act && $urandom_range(0, 2) == 0) begin
        f_act  = 1'b1;
        f_addr = rand_addr();
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act    = 1'b1;
        dd_addr  = rand_addr();
        dd_wdata = $urandom;
        dd_len   = 2'($urandom_range(0, 3));
        dd_st    = 1'($urandom_range(0, 1));
        dd_uns   = 1'($urandom_range(0, 1));
      end
      if_req_v[idx]  = f_act;
      if_addr_v[idx] = f_addr;
      d_req_v[idx]   = d_act;
      d_addr_v[idx]  = dd_addr;
      d_wdata_v[idx] = dd_wdata;
      d_len_v[idx]   = dd_len;
      d_store_v[idx] = dd_st;
      d_uns_v[idx]   = dd_uns;
      #1;
      gf = 1'b0;
      gd = 1'b0;
      if (c >= free_cyc) begin
        if (f_act && (!d_act || last_data)) gf = 1'b1;
        else if (d_act)                     gd = 1'b1;
      end
      e_ld = (c == acc + 1) && !c_err && !c_st;
      e_st = (c == acc + 1) && !c_err && c_st;
      chk("rnd_ready", idx, 64'({if_ready_v[idx], d_ready_v[idx]}), 64'({gf, gd}));
      chk("rnd_strobes", idx, 64'({m_ld_v[idx], m_st_v[idx]}), 64'({e_ld, e_st}));
      chk("rnd_valids", idx, 64'({if_rv_v[idx], d_rv_v[idx]}),
          64'({(c == rsp) && !c_data, (c == rsp) && c_data}));
      if (c > acc && c <= rsp) begin
        chk("rnd_mem_fields", idx, 64'({m_len_v[idx], m_uns_v[idx], m_addr_v[idx]}),
            64'({c_len, c_uns, c_addr}));
        if (c_data && c_st) chk("rnd_mem_wdata", idx, 64'(m_wdata_v[idx]), 64'(c_wdata));
      end
      if (c == rsp) begin
        expd = (c_err || c_st) ? 32'd0 : ram_word(c_addr);
        if (c_data) begin
          chk("rnd_d_resp", idx, 64'({d_re_v[idx], d_rd_v[idx]}), 64'({c_err, expd}));
          chk("rnd_if_quiet", idx, 64'({if_re_v[idx], if_rd_v[idx]}), 64'd0);
        end else begin
          chk("rnd_if_resp", idx, 64'({if_re_v[idx], if_rd_v[idx]}), 64'({c_err, expd}));
          chk("rnd_d_quiet", idx, 64'({d_re_v[idx], d_rd_v[idx]}), 64'd0);
        end
      end
      if (gf || gd) begin
        c_data = gd;
        if (gf) begin
          c_addr = f_addr; c_len = 2'd3; c_uns = 1'b1; c_st = 1'b0; c_wdata = '0;
          f_act = 1'b0;
        end else begin
          c_addr = dd_addr; c_len = dd_len; c_uns = dd_uns; c_st = dd_st; c_wdata = dd_wdata;
          d_act = 1'b0;
        end
        c_err = (c_len == 2'd2) || ((c_len == 2'd1) && c_addr[0]) ||
                ((c_len == 2'd3) && (c_addr[1:0] != 2'b00));
        acc = c;
        rsp = c + 1 + ((c_err || c_st) ? 0 : lat);
        free_cyc  = rsp + 1;
        last_data = gd;
        $display("[TB] rnd lat=%0d cyc=%0d grant=%s addr=%h len=%0d store=%0b err=%0b",
                 lat, c, gd ? "data " : "fetch", c_addr, c_len, c_st, c_err);
      end
    end
    @(negedge clk);
    if_req_v[idx] = 1'b0;
    d_req_v[idx]  = 1'b0;
    repeat (lat + 3) @(negedge clk);
  endtask

  vec_t vecs[12];
  int   gseq[$];
  int   both;
  int   stray;

  initial begin
    vecs[0]  = '{1, 1'b0, 1'b0, 32'h100, 32'h0,        2'd3, 1'b1, 3, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1, 1'b1, 1'b1, 32'h203, 32'hAB,       2'd0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[2]  = '{1, 1'b1, 1'b0, 32'h101, 32'h0,        2'd1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1, 1'b1, 1'b0, 32'h100, 32'h0,        2'd2, 1'b0, 1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1, 1'b0, 1'b0, 32'h102, 32'h0,        2'd3, 1'b1, 1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1, 1'b1, 1'b0, 32'h204, 32'h0,        2'd3, 1'b0, 3, 1'b0, 1'b1, 1'b0, 32'h0204FDFB};
    vecs[6]  = '{2, 1'b1, 1'b0, 32'h2,   32'h0,        2'd0, 1'b1, 4, 1'b0, 1'b1, 1'b0, 32'h0002FFFD};
    vecs[7]  = '{0, 1'b1, 1'b1, 32'h207, 32'h1234,     2'd1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{0, 1'b1, 1'b1, 32'h206, 32'h1234,     2'd1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[9]  = '{3, 1'b0, 1'b0, 32'h104, 32'h0,        2'd3, 1'b1, 5, 1'b0, 1'b1, 1'b0, 32'h0104FEFB};
    vecs[10] = '{0, 1'b1, 1'b0, 32'h3,   32'h0,        2'd0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 32'h0003FFFC};
    vecs[11] = '{2, 1'b1, 1'b1, 32'h30A, 32'h5A5A5A5A, 2'd3, 1'b0, 1, 1'b1, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < N; i++) do_reset(i);
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Both ports requesting continuously after reset: grants alternate F,D,F,D,
    // one ready cycle per transaction, one load every 2+RAM_LATENCY cycles.
    do_reset(0);
    @(negedge clk);
    if_req_v[0] = 1'b1; if_addr_v[0] = 32'h20;
    d_req_v[0]  = 1'b1; d_store_v[0] = 1'b0; d_addr_v[0] = 32'h10; d_len_v[0] = 2'd3;
    both = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (if_ready_v[0] && d_ready_v[0]) both++;
      if (if_ready_v[0]) gseq.push_back(0);
      if (d_ready_v[0])  gseq.push_back(1);
      @(negedge clk);
    end
    if_req_v[0] = 1'b0;
    d_req_v[0]  = 1'b0;
    chk("alt_both_ready", 0, 64'(both), 64'd0);
    chk("alt_grant_count", 0, 64'(gseq.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("alt_grant_order", 0, 64'((i < gseq.size()) ? gseq[i] : 99), 64'(i % 2));
    $display("[TB] alternation lat=1 grants=%0d", gseq.size());
    repeat (4) @(negedge clk);

    // Reset pulsed during WAIT of a fetch: outputs drop at once, no response ever,
    // and the grant pointer returns to "fetch wins the tie".
    do_reset(3);
    @(negedge clk);
    if_req_v[3] = 1'b1; if_addr_v[3] = 32'h40;
    #1;
    chk("rw_accept", 3, 64'(if_ready_v[3]), 64'd1);
    @(negedge clk);
    if_req_v[3] = 1'b0;
    #1;
    chk("rw_load_strobe", 3, 64'(m_ld_v[3]), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset_v[3] = 1'b1;
    #1;
    chk_zero("rw_reset", 3);
    @(negedge clk);
    reset_v[3] = 1'b0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (if_rv_v[3] || d_rv_v[3]) stray++;
      @(negedge clk);
    end
    chk("rw_no_response", 3, 64'(stray), 64'd0);
    if_req_v[3] = 1'b1; if_addr_v[3] = 32'h60;
    d_req_v[3]  = 1'b1; d_store_v[3] = 1'b0; d_addr_v[3] = 32'h44; d_len_v[3] = 2'd3;
    #1;
    chk("rw_tie_fetch", 3, 64'({if_ready_v[3], d_ready_v[3]}), 64'(2'b10));
    @(negedge clk);
    if_req_v[3] = 1'b0;
    d_req_v[3]  = 1'b0;
    repeat (6) @(negedge clk);
    run_vec('{3, 1'b1, 1'b0, 32'h44, 32'h0, 2'd3, 1'b0, 5, 1'b0, 1'b1, 1'b0, 32'h0044FFBB});

    for (int i = 0; i < N; i++) rand_run(i, 250);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
